// File: rtl/play_sequencer.sv
// Song auto-play scheduler: walks a synchronous song ROM, times notes and gaps, and lets a live key override the note path.
// Define PLAY_LOOP_EN to restart the song at its end marker instead of finishing with a done pulse.
module play_sequencer #(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned GAP_CYCLES = 1_000_000,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              key_valid,
  input  logic [3:0]        key_note,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic [3:0]        current_track,
  output logic              playing,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_MAX = (TICK_DIV > GAP_CYCLES) ? TICK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_PAUSED, S_DONE
  } state_t;

  state_t            state, state_n, ret_state, ret_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [3:0]        dur, dur_n, seq_track, track_n;
  logic [ADDR_W-1:0] addr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ret_state     <= S_PLAY;
      cnt           <= '0;
      dur           <= '0;
      seq_track     <= '0;
      rom_addr      <= '0;
      current_track <= '0;
      playing       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      ret_state     <= ret_n;
      cnt           <= cnt_n;
      dur           <= dur_n;
      seq_track     <= track_n;
      rom_addr      <= addr_n;
      // Outputs are registered from next-state so they line up with the state they describe.
      playing       <= key_valid || (state_n == S_PLAY);
      current_track <= key_valid ? key_note : track_n;
      busy          <= !((state_n == S_IDLE) || (state_n == S_DONE));
      done          <= (state_n == S_DONE) && (state != S_DONE);
    end
  end

  always_comb begin
    state_n = state;
    ret_n   = ret_state;
    cnt_n   = cnt;
    dur_n   = dur;
    track_n = seq_track;
    addr_n  = rom_addr;

    case (state)
      S_IDLE, S_DONE: ;
      S_FETCH: state_n = S_LOAD;
      S_LOAD: begin
        if (!rom_data[8]) begin
          track_n = rom_data[3:0];
          dur_n   = rom_data[7:4];
          cnt_n   = '0;
          state_n = S_PLAY;
        end else begin
`ifdef PLAY_LOOP_EN
          addr_n  = '0;
          state_n = S_FETCH;
`else
          state_n = S_DONE;
`endif
        end
      end
      S_PLAY: begin
        if (cnt == TICK_LAST) begin
          cnt_n = '0;
          if (dur == '0) state_n = S_GAP;
          else           dur_n   = dur - 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          addr_n  = rom_addr + 1'b1;
          state_n = S_FETCH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PAUSED: if (pause) state_n = ret_state;
      default: state_n = S_IDLE;
    endcase

    // The pulse cycle itself still counts; pausing parks whatever state the count leads to.
    if (pause && ((state == S_PLAY) || (state == S_GAP)) &&
        ((state_n == S_PLAY) || (state_n == S_GAP))) begin
      ret_n   = state_n;
      state_n = S_PAUSED;
    end

    if (stop || start) begin
      state_n = stop ? S_IDLE : S_FETCH;
      addr_n  = '0;
      cnt_n   = '0;
      dur_n   = '0;
      track_n = seq_track;
    end
  end

endmodule

// File: doc/play_sequencer.md
# play_sequencer

Auto-play scheduler for the piano's note/LED path. It walks a song stored in an external synchronous ROM and times each note and inter-note gap with clock-derived counters. It drives the `current_track` / `playing` pair consumed by the LED indicator and tone generator. Live keyboard input is arbitrated in front of the song stream, so a pressed key always owns the shared note path.

## Interface
Parameters:
- `TICK_DIV`, default 12_500_000, is the number of clk cycles per duration unit (125 ms at 100 MHz). Minimum 1.
- `GAP_CYCLES`, default 1_000_000, is the number of silent clk cycles between consecutive notes. Minimum 1.
- `ADDR_W`, default 6, is the song ROM address width.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that starts playback from address 0.
- `pause` in 1: single-cycle pulse that toggles pause and resume.
- `stop` in 1: single-cycle pulse that aborts playback and returns to idle.
- `key_valid` in 1: level, high while a live key is pressed.
- `key_note` in 4: note index of the live key.
- `rom_addr` out ADDR_W: song ROM address. It is registered.
- `rom_data` in 9: ROM word returned one cycle after `rom_addr`. The fields are:
  - [8] end marker.
  - [7:4] duration field d; the note lasts d+1 units.
  - [3:0] note index.
- `current_track` out 4: note index to the LED and tone path. It is registered.
- `playing` out 1: note-active flag. It is registered.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: one-cycle pulse when the song ends.

## Operation
States are IDLE, FETCH, LOAD, PLAY, GAP, PAUSED and DONE.

Reset values:
- State is IDLE.
- `rom_addr`, `current_track`, `playing`, `busy` and `done` are all 0.
- The duration counter and tick counter are 0.

Transitions:
- **IDLE or DONE + start:** go to FETCH with `rom_addr` = 0.
- **FETCH:** lasts one cycle, for the ROM read latency. Then go to LOAD.
- **LOAD:** sample `rom_data`.
  - If bit 8 = 0: latch the note, load the duration counter with d, and go to PLAY.
  - If bit 8 = 1: end handling applies (see Configuration). No note is played.
- **PLAY:** `playing` = 1 and `current_track` = the latched note.
  - The tick counter counts 0..TICK_DIV-1.
  - When the tick counter wraps and the duration counter is 0, go to GAP. Otherwise decrement the duration counter.
  - Total PLAY length is exactly (d+1)·TICK_DIV cycles.
- **GAP:** `playing` = 0 and `current_track` holds its value.
  - After GAP_CYCLES cycles: `rom_addr` ← `rom_addr` + 1, then go to FETCH.
  - The address wraps from 2^ADDR_W−1 to 0 with no special handling.
- **PLAY or GAP + pause:** go to PAUSED.
  - Save the return state (PLAY or GAP).
  - Freeze all counters.
  - `playing` = 0.
- **PAUSED + pause:** return to the saved state with counters intact. In PLAY, `playing` reasserts.
- **pause in IDLE, FETCH, LOAD or DONE:** ignored.
- **stop in any state:** go to IDLE.
  - `rom_addr` = 0, `playing` = 0, counters cleared.
  - No `done` pulse.
- **start in any non-idle state (including PAUSED):** restart at FETCH with address 0 and counters cleared.
- **Simultaneous pulses:** priority is stop > start > pause.

Live-key arbitration:
- While `key_valid` = 1, `current_track` = `key_note` and `playing` = 1, regardless of sequencer state.
- The sequencer keeps running underneath and is not frozen.
- When `key_valid` falls, the outputs revert to the sequencer's values on the next cycle.

Reset mid-operation: an asynchronous return to the reset values. No `done` pulse.

## Timing
- All outputs are registered.
- Start latency: `start` sampled at edge N gives FETCH at N+1 and LOAD at N+2. `playing` rises at N+3.
- Note-to-note spacing is (d+1)·TICK_DIV + GAP_CYCLES + 2 cycles (the 2 cycles are FETCH and LOAD).
- `done` is asserted for exactly the one cycle in which DONE is entered. `busy` falls in that same cycle.
- Key override latency: a `key_valid` or `key_note` change appears on the outputs one cycle later.
- Pause and resume take effect one cycle after the pulse. No counts are lost or duplicated.

## Configuration
- `PLAY_LOOP_EN` defined: an end marker in LOAD sets `rom_addr` = 0 and goes to FETCH. The song repeats indefinitely. `done` never pulses.
- `PLAY_LOOP_EN` not defined: an end marker goes to DONE. `done` pulses, `playing` = 0, and `rom_addr` holds its value.

## Test plan
All scenarios use TICK_DIV = 4 and GAP_CYCLES = 2.

1. **Basic play and end:** ROM {0x013, 0x100} (note 3 with d = 1, then end); start at cycle 0.
   - `playing` = 1 with `current_track` = 3 for cycles 3–10.
   - Gap in cycles 11–12.
   - `done` = 1 only at cycle 15; `busy` = 0 from cycle 15.
2. **Pause and resume:** a 0x0F5 note (note 5, d = 15).
   - Pulse pause 10 cycles into PLAY: `playing` = 0 and counters frozen for 20 cycles.
   - Pulse pause again: the total cycles spent in PLAY equal exactly 64.
3. **Stop and restart priority:**
   - stop mid-PLAY gives IDLE, `rom_addr` = 0, `playing` = 0 one cycle later, with no `done` pulse.
   - stop and start in the same cycle gives IDLE.
4. **Key override:** hold `key_valid` with `key_note` = 0xC during a note-2 PLAY.
   - Output is `current_track` = 0xC, `playing` = 1.
   - On release it reverts to 2, or to `playing` = 0 if the sequencer has reached GAP.
5. **Address wrap:** ADDR_W = 2 with four non-end words.
   - `rom_addr` sequence is 0, 1, 2, 3, 0.
6. **Loop option:**
   - With `PLAY_LOOP_EN`, the scenario-1 song replays note 3, with no `done` pulse.
   - Asserting `rst` mid-PLAY sets all outputs to 0 immediately.
